zkbdmus_spiload: RTL
====================

# zkbdmus_spiload

Serial-slave front end that receives keyboard-matrix, mouse and Kempston-joystick reports from the board controller over a 3-wire SPI-style link and converts them into the parallel data plus single-cycle strobes consumed by the Z80 keyboard/mouse port mux. It sits between the controller pins and the port mux. It produces the 40-bit key vector with its strobe, and one shared 8-bit mouse/joystick byte with four per-destination strobes.

## Interface
Parameters:
- none

Ports:
- fclk  in  1  system clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- spics_n  in  1  frame select from controller, async, active low
- spick  in  1  serial clock from controller, async; data is sampled on its rising edge
- spido  in  1  serial data from controller, async, MSB first
- kbd_out  out  40  key vector; bit n = key n pressed (1 = pressed)
- kbd_stb  out  1  one-cycle pulse; kbd_out is valid from this cycle onwards
- mus_out  out  8  last completed mouse/joystick data byte
- mus_xstb  out  1  one-cycle pulse; mus_out holds the mouse X value
- mus_ystb  out  1  one-cycle pulse; mus_out holds the mouse Y value
- mus_btnstb  out  1  one-cycle pulse; mus_out holds the mouse buttons
- kj_stb  out  1  one-cycle pulse; mus_out holds the Kempston joystick byte

## Operation
- Input conditioning: spics_n, spick and spido each pass through a 2-flop synchroniser. Edges are detected against a third registered copy. The fclk frequency must be at least 8× the spick frequency.
- Bit path: on each detected spick rise while CS is low, the synchronised spido shifts into an 8-bit shift register (MSB first) and a 3-bit counter increments. When the counter wraps from 7 to 0, the byte is complete.
- States:
  - WAITCS: wait for CS high. Entered from reset.
  - IDLE: CS high; counters cleared.
  - CMD: the first byte of the frame is the command.
  - DATA: collecting payload bytes.
  - SKIP: discarding bytes until CS goes high.
- Transitions:
  - WAITCS -> IDLE when synchronised CS is high.
  - IDLE -> CMD on a CS falling edge.
  - Any state other than IDLE/WAITCS -> IDLE on a CS rising edge. The partial byte is discarded and no strobe is issued.
- Commands (decided when the command byte completes):
  - 0x10 keyboard: 5 payload bytes. Byte 0 goes to kbd_out[39:32], byte 4 to kbd_out[7:0].
  - 0x20 mouse X, 0x21 mouse Y, 0x22 buttons, 0x23 joystick: 1 payload byte each.
  - Any other command: go to SKIP.
- Keyboard payload:
  - Bytes accumulate in an internal 40-bit register. kbd_out is updated from it only when byte 4 completes, so kbd_out never shows a partial vector.
  - kbd_stb pulses on that same update.
  - Go to SKIP afterwards.
- Mouse/joystick payload:
  - When the byte completes, the byte loads into mus_out and exactly one matching strobe pulses.
  - Go to SKIP afterwards, so extra bytes are ignored.
- A frame aborted before its last payload byte leaves kbd_out and mus_out unchanged.
- Only one strobe can be high in any cycle.

## Timing
- Reset values: kbd_out = 0, mus_out = 0, all strobes = 0, state = WAITCS, counters = 0.
- Reset asserted mid-frame: the frame is aborted. No new frame is accepted until CS has been seen high, then falls again.
- Latency: let cycle E be the fclk cycle in which the final spick rise of a payload byte is detected. In cycle E+1, the data output is updated and the strobe is high. The strobe is high for exactly one cycle. The pin-to-detection delay is 3 fclk cycles.
- A CS rise detected in the same cycle as the final bit's spick rise takes priority: the byte is discarded and no strobe is issued.
- A CS fall and a spick rise detected in the same cycle: the spick edge is ignored, and bit collection starts with the next rise.
- The data outputs hold their value indefinitely between strobes.

## Test plan
- Reset, then idle for 20 cycles -> kbd_out = 0, mus_out = 0, no strobe pulses.
- Frame 0x10, 0x80, 0x00, 0x00, 0x00, 0x01 -> kbd_out = 0x80_0000_0001, a single kbd_stb pulse one cycle after the last bit is detected, and no change to kbd_out before that.
- Frames 0x20/0x7F, 0x21/0x80, 0x22/0xFA, 0x23/0x05 -> mus_out = 0x7F, 0x80, 0xFA, 0x05 in turn, each with only its own strobe pulsing (xstb, ystb, btnstb, kj_stb).
- Keyboard frame with CS raised after 3 payload bytes, then a mid-byte abort of a 0x20 frame -> kbd_out and mus_out unchanged, no strobes.
- Unknown command 0x55 followed by bytes 0x10, 0xAA, then a 0x20/0x33 frame -> no strobe during the first frame; mus_out = 0x33 with mus_xstb after the second.
- rst pulsed mid keyboard frame with CS held low, followed by further spick edges -> no strobes until CS goes high; the next complete frame is accepted normally.

Source files
------------

// File: rtl/zkbdmus_spiload.sv
// Serial-slave front end: receives keyboard/mouse/joystick reports over a 3-wire
// SPI-style link and presents them as parallel data with single-cycle strobes.
module zkbdmus_spiload (
    input  logic        fclk,
    input  logic        rst,
    input  logic        spics_n,
    input  logic        spick,
    input  logic        spido,
    output logic [39:0] kbd_out,
    output logic        kbd_stb,
    output logic [7:0]  mus_out,
    output logic        mus_xstb,
    output logic        mus_ystb,
    output logic        mus_btnstb,
    output logic        kj_stb
);

    typedef enum logic [2:0] {
        WAITCS = 3'd0,
        IDLE   = 3'd1,
        CMD    = 3'd2,
        DATA   = 3'd3,
        SKIP   = 3'd4
    } state_t;

    state_t state;

    // [0],[1] form the synchroniser; [2] is the delayed copy for edge detection.
    logic [2:0] cs_sr;
    logic [2:0] ck_sr;
    logic [1:0] do_sr;

    logic       cs_high;
    logic       cs_rise;
    logic       cs_fall;
    logic       ck_rise;
    logic       do_s;

    logic [6:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic        is_kbd;
    logic [1:0]  mus_sel;
    logic [31:0] kbd_acc;
    logic [7:0]  new_byte;
    logic        byte_done;

    assign cs_high   = cs_sr[1];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign ck_rise   = ck_sr[1] & ~ck_sr[2];
    assign do_s      = do_sr[1];
    assign new_byte  = {shift_reg, do_s};
    assign byte_done = ck_rise && (bit_cnt == 3'd7);

    // Chains reset low so a CS line held low through reset never looks like a fresh fall.
    always_ff @(posedge fclk) begin
        if (rst) begin
            cs_sr <= 3'b000;
            ck_sr <= 3'b000;
            do_sr <= 2'b00;
        end else begin
            cs_sr <= {cs_sr[1:0], spics_n};
            ck_sr <= {ck_sr[1:0], spick};
            do_sr <= {do_sr[0], spido};
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state      <= WAITCS;
            shift_reg  <= 7'd0;
            bit_cnt    <= 3'd0;
            byte_idx   <= 3'd0;
            is_kbd     <= 1'b0;
            mus_sel    <= 2'd0;
            kbd_acc    <= 32'd0;
            kbd_out    <= 40'd0;
            mus_out    <= 8'd0;
            kbd_stb    <= 1'b0;
            mus_xstb   <= 1'b0;
            mus_ystb   <= 1'b0;
            mus_btnstb <= 1'b0;
            kj_stb     <= 1'b0;
        end else begin
            kbd_stb    <= 1'b0;
            mus_xstb   <= 1'b0;
            mus_ystb   <= 1'b0;
            mus_btnstb <= 1'b0;
            kj_stb     <= 1'b0;

            case (state)
                WAITCS: begin
                    bit_cnt  <= 3'd0;
                    byte_idx <= 3'd0;
                    if (cs_high) state <= IDLE;
                end
                IDLE: begin
                    bit_cnt  <= 3'd0;
                    byte_idx <= 3'd0;
                    if (cs_fall) state <= CMD;
                end
                default: begin
                    // CS rise wins over a coincident final bit: the byte is dropped.
                    if (cs_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= 3'd0;
                        byte_idx <= 3'd0;
                    end else if (ck_rise) begin
                        shift_reg <= new_byte[6:0];
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            case (state)
                                CMD: begin
                                    byte_idx <= 3'd0;
                                    mus_sel  <= new_byte[1:0];
                                    if (new_byte == 8'h10) begin
                                        is_kbd <= 1'b1;
                                        state  <= DATA;
                                    end else if (new_byte[7:2] == 6'b001000) begin
                                        is_kbd <= 1'b0;
                                        state  <= DATA;
                                    end else begin
                                        state  <= SKIP;
                                    end
                                end
                                DATA: begin
                                    if (is_kbd) begin
                                        kbd_acc <= {kbd_acc[23:0], new_byte};
                                        if (byte_idx == 3'd4) begin
                                            kbd_out <= {kbd_acc, new_byte};
                                            kbd_stb <= 1'b1;
                                            state   <= SKIP;
                                        end else begin
                                            byte_idx <= byte_idx + 3'd1;
                                        end
                                    end else begin
                                        mus_out <= new_byte;
                                        case (mus_sel)
                                            2'd0:    mus_xstb   <= 1'b1;
                                            2'd1:    mus_ystb   <= 1'b1;
                                            2'd2:    mus_btnstb <= 1'b1;
                                            default: kj_stb     <= 1'b1;
                                        endcase
                                        state <= SKIP;
                                    end
                                end
                                default: state <= SKIP;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
